mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
Round-robin arbiter that shares one memory/IO bus between N PicoRV32 cores, each using the native valid/ready memory interface. It registers the winning request and drives it onto a single downstream port (block RAM, LED and UART decode). It returns read data and a one-cycle ready pulse to the winning core. A watchdog completes stalled transfers so that an unmapped address cannot hang a core.

Parameters:
N_PORTS, 4, number of requesting cores (2..8)
PORT_BITS, $clog2(N_PORTS), width of the grant index
TIMEOUT, 255, maximum cycles to wait for dn_ready; 0 disables the watchdog

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
up_valid  in  N_PORTS  per-core request, held until that core's up_ready
up_addr  in  32*N_PORTS  per-core byte address, core k at [32k+31:32k]
up_wdata  in  32*N_PORTS  per-core write data
up_wstrb  in  4*N_PORTS  per-core byte strobes; 0 means read
up_ready  out  N_PORTS  per-core completion pulse, one-hot
up_rdata  out  32*N_PORTS  per-core read data, valid while the matching up_ready is high
dn_valid  out  1  downstream request
dn_addr  out  32  registered address of the granted request
dn_wdata  out  32  registered write data
dn_wstrb  out  4  registered strobes
dn_ready  in  1  downstream completion; may assert in the same cycle dn_valid rises
dn_rdata  in  32  downstream read data, sampled when dn_ready is high
grant_id  out  PORT_BITS  index of the core currently owning the bus
bus_err  out  1  one-cycle pulse when a watchdog timeout completes a transfer

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all up_ready=0; dn_valid=0; bus_err=0.
  - dn_addr, dn_wdata and dn_wstrb=0; up_rdata=0; grant_id=0; priority pointer=0; watchdog=0.
  - Outputs clear immediately, without waiting for a clock edge.
- States:
  - IDLE: if any up_valid bit is set, pick a winner and go to ISSUE; otherwise stay.
  - ISSUE: dn_valid=1. When dn_ready=1, capture dn_rdata and go to RESP. If the watchdog reaches TIMEOUT, go to RESP with rdata=0 and raise bus_err.
  - RESP: drive up_ready[grant_id]=1 for exactly one cycle, then return to IDLE.
- Arbitration:
  - Search up_valid starting at index ptr, then ptr+1, and so on, wrapping modulo N_PORTS.
  - The first set bit wins. On grant, ptr <= winner+1 mod N_PORTS.
  - Any core with a continuous request is served within N_PORTS grants (starvation-free).
- Winner payload: its addr, wdata and wstrb are registered into dn_* on the IDLE->ISSUE edge. dn_* stay stable for the whole of ISSUE.
- Latency:
  - With zero-wait downstream (dn_ready in the first ISSUE cycle), up_ready rises 2 cycles after the cycle up_valid is first sampled in IDLE.
  - Minimum spacing between grants is 3 cycles.
- The RESP->IDLE path never re-grants on the up_ready cycle. The served core's up_valid is ignored in that cycle; the core may re-request in the following IDLE cycle.
- up_rdata: written only for lane grant_id, in the ISSUE->RESP transition. Other lanes hold their previous values.
- Write transfers (wstrb != 0) also capture dn_rdata; cores ignore it.
- Watchdog:
  - Counts cycles spent in ISSUE and clears on leaving ISSUE.
  - Timeout fires when the count equals TIMEOUT-1 with dn_ready=0.
  - If dn_ready=1 in the same cycle as the timeout, dn_ready wins: normal data, no bus_err.
- If up_valid of the granted core drops mid-transfer (protocol violation), the transfer still completes and up_ready still pulses.
- If resetn asserts mid-ISSUE, dn_valid drops asynchronously and the transfer is abandoned. The downstream side must treat dn_valid falling as a cancel.
- N_PORTS=1: the arbiter degenerates to a registered pass-through; ptr stays 0.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding localparams ST_IDLE=0, ST_ISSUE=1, ST_RESP=2 (2 bits).
  - Watchdog width localparam WD_BITS=$clog2(TIMEOUT+1).
- One sub-module, rr_priority_pick: combinational rotate plus priority encoder.
  - Inputs: req[N_PORTS], ptr[PORT_BITS].
  - Outputs: any, winner[PORT_BITS].
  - Instantiated once.

Test Plan:
- Single request: core 2 reads 0x0000_0040, downstream returns 0xDEADBEEF with zero wait -> dn_addr=0x40 one cycle after the request; up_ready[2] pulses 2 cycles after the request; up_rdata lane 2=0xDEADBEEF; grant_id=2.
- All four cores request continuously from reset (ptr=0) -> grant order 0,1,2,3,0; every up_ready is a single-cycle one-hot pulse spaced 3 cycles apart.
- Core 1 writes 0x1000_0000 data 0x0000_00A5 wstrb 0001 while core 3 also requests -> dn_wstrb=0001 and dn_wdata=0xA5 on core 1's grant; core 3 is served next; core 1 is not re-granted on its up_ready cycle.
- Watchdog with TIMEOUT=8: core 0 reads 0x3000_0000 and dn_ready stays 0 -> bus_err and up_ready[0] pulse together after 8 ISSUE cycles; up_rdata lane 0=0. Repeat with dn_ready=1 in the 8th ISSUE cycle -> no bus_err, normal data.
- Asynchronous reset mid-ISSUE, asserted between clock edges -> dn_valid and up_ready go 0 immediately; after release, ptr=0 and the next grant goes to the lowest-index requester.
- Downstream stall of 3 cycles on a core 3 read -> dn_addr, dn_wdata and dn_wstrb are stable throughout; up_ready[3] rises exactly one cycle after dn_ready.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and watchdog sizing shared by the round-robin memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2} state_t;
  function automatic int wd_bits(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction
endpackage

// File: rtl/mem_rr_arbiter_pick.sv
// rr_priority_pick: rotating priority encoder; req/ptr in, any/winner = first set req at or after ptr
module rr_priority_pick #(
  parameter int N_PORTS   = 4,
  parameter int PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 any,
  output logic [PORT_BITS-1:0] winner
);
  logic [PORT_BITS-1:0] idx;
  always_comb begin
    any = |req;
    winner = '0;
    idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = PORT_BITS'((int'(ptr) + i) % N_PORTS);
      winner = req[idx] ? idx : winner;
    end
  end
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one valid/ready bus; up_* per-core side, dn_* downstream port, grant_id owner, bus_err timeout pulse
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_PORTS-1:0]     up_valid,
  input  logic [32*N_PORTS-1:0]  up_addr,
  input  logic [32*N_PORTS-1:0]  up_wdata,
  input  logic [4*N_PORTS-1:0]   up_wstrb,
  output logic [N_PORTS-1:0]     up_ready,
  output logic [32*N_PORTS-1:0]  up_rdata,
  output logic                   dn_valid,
  output logic [31:0]            dn_addr,
  output logic [31:0]            dn_wdata,
  output logic [3:0]             dn_wstrb,
  input  logic                   dn_ready,
  input  logic [31:0]            dn_rdata,
  output logic [PORT_BITS-1:0]   grant_id,
  output logic                   bus_err
);
  localparam int WD_BITS = wd_bits(TIMEOUT);
  state_t state;
  logic [PORT_BITS-1:0] ptr, winner;
  logic any, wd_expired;
  logic [WD_BITS-1:0] wd;
  logic [31:0] addr_a [N_PORTS];
  logic [31:0] wdata_a [N_PORTS];
  logic [3:0] wstrb_a [N_PORTS];
  logic [31:0] rdata_q [N_PORTS];
  for (genvar k = 0; k < N_PORTS; k++) begin : g_lane
    assign addr_a[k] = up_addr[32*k +: 32];
    assign wdata_a[k] = up_wdata[32*k +: 32];
    assign wstrb_a[k] = up_wstrb[4*k +: 4];
    assign up_rdata[32*k +: 32] = rdata_q[k];
  end
  rr_priority_pick #(.N_PORTS(N_PORTS), .PORT_BITS(PORT_BITS)) u_pick (
    .req(up_valid),
    .ptr(ptr),
    .any(any),
    .winner(winner)
  );
  // dn_ready in the final cycle beats the watchdog
  assign wd_expired = (TIMEOUT != 0) && !dn_ready && (wd == WD_BITS'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ST_IDLE;
      ptr <= '0;
      grant_id <= '0;
      wd <= '0;
      dn_valid <= 1'b0;
      dn_addr <= '0;
      dn_wdata <= '0;
      dn_wstrb <= '0;
      up_ready <= '0;
      bus_err <= 1'b0;
      rdata_q <= '{default: '0};
    end else begin
      up_ready <= '0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE:
          if (any) begin
            state <= ST_ISSUE;
            dn_valid <= 1'b1;
            grant_id <= winner;
            ptr <= (winner == PORT_BITS'(N_PORTS - 1)) ? '0 : winner + 1'b1;
            dn_addr <= addr_a[winner];
            dn_wdata <= wdata_a[winner];
            dn_wstrb <= wstrb_a[winner];
          end
        ST_ISSUE:
          if (dn_ready || wd_expired) begin
            state <= ST_RESP;
            dn_valid <= 1'b0;
            wd <= '0;
            up_ready <= N_PORTS'(1) << grant_id;
            bus_err <= !dn_ready;
            rdata_q[grant_id] <= dn_ready ? dn_rdata : '0;
          end else
            wd <= wd + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level round-robin model
module tb_mem_rr_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [3:0] up_valid = '0;
  logic [127:0] up_addr = '0;
  logic [127:0] up_wdata = '0;
  logic [15:0] up_wstrb = '0;
  logic [3:0] up_ready;
  logic [127:0] up_rdata;
  logic dn_valid;
  logic [31:0] dn_addr, dn_wdata;
  logic [3:0] dn_wstrb;
  logic dn_ready = 1'b0;
  logic [31:0] dn_rdata = '0;
  logic [1:0] grant_id;
  logic bus_err;
  int checks = 0;
  int failures = 0;

  mem_rr_arbiter #(.N_PORTS(4), .PORT_BITS(2), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .up_valid(up_valid), .up_addr(up_addr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
    .up_ready(up_ready), .up_rdata(up_rdata),
    .dn_valid(dn_valid), .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb),
    .dn_ready(dn_ready), .dn_rdata(dn_rdata),
    .grant_id(grant_id), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000ns, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int k);
    return 4'(1 << k);
  endfunction

  function automatic logic [31:0] lane(input int k);
    return up_rdata[7'(32 * k) +: 32];
  endfunction

  // reference rule: first requester found scanning from p upward, modulo 4
  function automatic int rr_pick(input logic [3:0] req, input int p);
    for (int i = 0; i < 4; i++)
      if (req[2'((p + i) % 4)]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    up_addr[7'(32 * k) +: 32] = a;
    up_wdata[7'(32 * k) +: 32] = w;
    up_wstrb[4'(4 * k) +: 4] = s;
    up_valid[2'(k)] = 1'b1;
  endtask

  task automatic clr_req(input int k);
    up_valid[2'(k)] = 1'b0;
  endtask

  task automatic do_reset();
    up_valid = '0;
    dn_ready = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dn_valid !== 1'b0 || up_ready !== 4'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: dn_valid=%b up_ready=%b bus_err=%b, expected 0 0000 0", dn_valid, up_ready, bus_err);
    end
    checks++;
    if (dn_addr !== 32'b0 || dn_wdata !== 32'b0 || dn_wstrb !== 4'b0) begin
      failures++;
      $display("FAIL reset_dn: addr=%h wdata=%h wstrb=%b, expected all zero", dn_addr, dn_wdata, dn_wstrb);
    end
    checks++;
    if (grant_id !== 2'd0 || up_rdata !== 128'b0) begin
      failures++;
      $display("FAIL reset_up: grant_id=%0d up_rdata=%h, expected 0 and 0", grant_id, up_rdata);
    end
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (dn_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: dn_valid=%b with no request, expected 0", dn_valid);
    end
  endtask

  task automatic test_single();
    dn_ready = 1'b1;
    dn_rdata = 32'hDEAD_BEEF;
    set_req(2, 32'h0000_0040, 32'h0, 4'b0000);
    tick();
    checks++;
    if (dn_valid !== 1'b1 || dn_addr !== 32'h40 || grant_id !== 2'd2 || up_ready !== 4'b0) begin
      failures++;
      $display("FAIL single_issue: dn_valid=%b addr=%h grant=%0d up_ready=%b, expected 1 00000040 2 0000", dn_valid, dn_addr, grant_id, up_ready);
    end
    tick();
    checks++;
    if (up_ready !== 4'b0100 || lane(2) !== 32'hDEAD_BEEF || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: up_ready=%b rdata2=%h bus_err=%b, expected 0100 deadbeef 0", up_ready, lane(2), bus_err);
    end
    clr_req(2);
    dn_ready = 1'b0;
    tick();
    checks++;
    if (up_ready !== 4'b0 || dn_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse: up_ready=%b dn_valid=%b after response, expected 0000 0", up_ready, dn_valid);
    end
  endtask

  task automatic test_all_four();
    int p = 0;
    int w = 0;
    do_reset();
    dn_ready = 1'b1;
    dn_rdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) set_req(k, 32'h100 + 32'(k), 32'(k), 4'b0000);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i % 3 == 1) begin
        w = rr_pick(up_valid, p);
        checks++;
        if (grant_id !== 2'(w) || dn_addr !== 32'h100 + 32'(w)) begin
          failures++;
          $display("FAIL rr_grant: cycle %0d grant=%0d addr=%h, expected %0d %h", i, grant_id, dn_addr, w, 32'h100 + 32'(w));
        end
      end
      checks++;
      if (up_ready !== ((i % 3 == 2) ? onehot(w) : 4'b0)) begin
        failures++;
        $display("FAIL rr_ready: cycle %0d up_ready=%b, expected %b", i, up_ready, (i % 3 == 2) ? onehot(w) : 4'b0);
      end
      if (i % 3 == 2) p = (w + 1) % 4;
    end
    up_valid = '0;
    dn_ready = 1'b0;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    dn_ready = 1'b1;
    dn_rdata = 32'h0BAD_F00D;
    set_req(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
    set_req(3, 32'h2000_0008, 32'h0, 4'b0000);
    tick();
    checks++;
    if (grant_id !== 2'd1 || dn_addr !== 32'h1000_0000 || dn_wdata !== 32'hA5 || dn_wstrb !== 4'b0001) begin
      failures++;
      $display("FAIL write_issue: grant=%0d addr=%h wdata=%h wstrb=%b, expected 1 10000000 000000a5 0001", grant_id, dn_addr, dn_wdata, dn_wstrb);
    end
    tick();
    checks++;
    if (up_ready !== 4'b0010) begin
      failures++;
      $display("FAIL write_resp: up_ready=%b, expected 0010", up_ready);
    end
    tick();
    checks++;
    if (dn_valid !== 1'b0 || up_ready !== 4'b0) begin
      failures++;
      $display("FAIL write_no_regrant: dn_valid=%b up_ready=%b after response, expected 0 0000", dn_valid, up_ready);
    end
    tick();
    checks++;
    if (grant_id !== 2'd3 || dn_addr !== 32'h2000_0008 || dn_wstrb !== 4'b0000) begin
      failures++;
      $display("FAIL write_next: grant=%0d addr=%h wstrb=%b, expected 3 20000008 0000", grant_id, dn_addr, dn_wstrb);
    end
    tick();
    checks++;
    if (up_ready !== 4'b1000) begin
      failures++;
      $display("FAIL write_next_resp: up_ready=%b, expected 1000", up_ready);
    end
    up_valid = '0;
    dn_ready = 1'b0;
    tick();
  endtask

  task automatic test_watchdog();
    dn_ready = 1'b0;
    dn_rdata = 32'hCAFE_F00D;
    set_req(0, 32'h3000_0000, 32'h0, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (dn_valid !== 1'b1 || up_ready !== 4'b0 || bus_err !== 1'b0) begin
        failures++;
        $display("FAIL wd_wait: issue cycle %0d dn_valid=%b up_ready=%b bus_err=%b, expected 1 0000 0", i, dn_valid, up_ready, bus_err);
      end
    end
    tick();
    checks++;
    if (up_ready !== 4'b0001 || bus_err !== 1'b1 || lane(0) !== 32'h0) begin
      failures++;
      $display("FAIL wd_fire: up_ready=%b bus_err=%b rdata0=%h, expected 0001 1 00000000", up_ready, bus_err, lane(0));
    end
    clr_req(0);
    tick();
    checks++;
    if (up_ready !== 4'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse: up_ready=%b bus_err=%b, expected 0000 0", up_ready, bus_err);
    end
    dn_rdata = 32'h600D_DA7A;
    set_req(0, 32'h3000_0000, 32'h0, 4'b0000);
    for (int i = 1; i <= 8; i++) tick();
    dn_ready = 1'b1;
    tick();
    checks++;
    if (up_ready !== 4'b0001 || bus_err !== 1'b0 || lane(0) !== 32'h600D_DA7A) begin
      failures++;
      $display("FAIL wd_race: up_ready=%b bus_err=%b rdata0=%h, expected 0001 0 600dda7a", up_ready, bus_err, lane(0));
    end
    clr_req(0);
    dn_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    dn_ready = 1'b0;
    set_req(2, 32'h0000_0044, 32'h0, 4'b0000);
    tick();
    checks++;
    if (dn_valid !== 1'b1 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL arst_pre: dn_valid=%b grant=%0d, expected 1 2", dn_valid, grant_id);
    end
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (dn_valid !== 1'b0 || up_ready !== 4'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL arst_clear: dn_valid=%b up_ready=%b grant=%0d mid-cycle, expected 0 0000 0", dn_valid, up_ready, grant_id);
    end
    clr_req(2);
    set_req(1, 32'h0000_1111, 32'h0, 4'b0000);
    set_req(3, 32'h0000_3333, 32'h0, 4'b0000);
    #2 resetn = 1'b1;
    tick();
    checks++;
    if (dn_valid !== 1'b1 || grant_id !== 2'd1 || dn_addr !== 32'h1111) begin
      failures++;
      $display("FAIL arst_ptr: dn_valid=%b grant=%0d addr=%h, expected 1 1 00001111", dn_valid, grant_id, dn_addr);
    end
    dn_ready = 1'b1;
    tick();
    up_valid = '0;
    dn_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    dn_ready = 1'b0;
    dn_rdata = 32'h7777_0003;
    set_req(3, 32'h5000_0010, 32'h1357_9BDF, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dn_valid !== 1'b1 || up_ready !== 4'b0 || dn_addr !== 32'h5000_0010 || dn_wdata !== 32'h1357_9BDF || dn_wstrb !== 4'b0000) begin
        failures++;
        $display("FAIL stall_stable: cycle %0d valid=%b ready=%b addr=%h wdata=%h wstrb=%b, expected 1 0000 50000010 13579bdf 0000", i, dn_valid, up_ready, dn_addr, dn_wdata, dn_wstrb);
      end
      set_req(0, $urandom, $urandom, 4'($urandom));
      if (i == 3) dn_ready = 1'b1;
      tick();
    end
    checks++;
    if (up_ready !== 4'b1000 || lane(3) !== 32'h7777_0003) begin
      failures++;
      $display("FAIL stall_resp: up_ready=%b rdata3=%h, expected 1000 77770003", up_ready, lane(3));
    end
    clr_req(3);
    tick();
    tick();
    checks++;
    if (grant_id !== 2'd0) begin
      failures++;
      $display("FAIL stall_next: grant=%0d, expected 0", grant_id);
    end
    tick();
    up_valid = '0;
    dn_ready = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] pend = '0;
    logic [3:0] served;
    logic [3:0] prev_req = '0;
    logic prev_dv = 1'b0;
    logic prev_idle = 1'b1;
    logic prev_resp = 1'b0;
    logic cur_idle, rose, exp_grant;
    logic [31:0] pa [4];
    logic [31:0] pw [4];
    logic [3:0] ps [4];
    int since [4];
    int mptr = 0;
    int cur = -1;
    int w = 0;
    int wcnt = 0;
    int done = 0;
    logic [31:0] exp_rd = '0;
    do_reset();
    for (int k = 0; k < 4; k++) since[2'(k)] = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      served = '0;
      if (up_ready !== 4'b0) begin
        checks++;
        if (cur < 0) begin
          failures++;
          $display("FAIL rand_resp: cycle %0d up_ready=%b with no transfer in flight, expected 0000", c, up_ready);
        end else if (up_ready !== onehot(cur) || bus_err !== 1'b0 || lane(cur) !== exp_rd) begin
          failures++;
          $display("FAIL rand_resp: cycle %0d up_ready=%b bus_err=%b rdata=%h, expected %b 0 %h", c, up_ready, bus_err, lane(cur), onehot(cur), exp_rd);
        end
        if (cur >= 0) begin
          pend[2'(cur)] = 1'b0;
          served = onehot(cur);
        end
        cur = -1;
        done++;
      end
      cur_idle = prev_resp || (prev_idle && prev_req == 4'b0);
      exp_grant = prev_idle && prev_req != 4'b0;
      rose = (dn_valid === 1'b1) && !prev_dv;
      checks++;
      if (rose !== exp_grant) begin
        failures++;
        $display("FAIL rand_grant_timing: cycle %0d grant_started=%b, expected %b", c, rose, exp_grant);
      end
      if (rose) begin
        w = rr_pick(prev_req, mptr);
        checks++;
        if (w < 0 || grant_id !== 2'(w) || dn_addr !== pa[2'(w)] || dn_wdata !== pw[2'(w)] || dn_wstrb !== ps[2'(w)]) begin
          failures++;
          $display("FAIL rand_payload: cycle %0d grant=%0d addr=%h wdata=%h wstrb=%b, expected core %0d", c, grant_id, dn_addr, dn_wdata, dn_wstrb, w);
        end
        if (w >= 0) begin
          for (int k = 0; k < 4; k++) begin
            if (k == w) since[2'(k)] = 0;
            else if (pend[2'(k)]) since[2'(k)]++;
            checks++;
            if (since[2'(k)] >= 4) begin
              failures++;
              $display("FAIL rand_starve: core %0d waited %0d grants, expected fewer than 4", k, since[2'(k)]);
            end
          end
          mptr = (w + 1) % 4;
          cur = w;
        end
        wcnt = int'($urandom_range(0, 3));
      end
      dn_rdata = $urandom;
      if (dn_valid === 1'b1 && wcnt == 0) begin
        dn_ready = 1'b1;
        exp_rd = dn_rdata;
      end else begin
        dn_ready = 1'b0;
        if (dn_valid === 1'b1) wcnt--;
      end
      for (int k = 0; k < 4; k++)
        if (!pend[2'(k)] && !served[2'(k)] && $urandom_range(0, 2) == 0) begin
          pend[2'(k)] = 1'b1;
          pa[2'(k)] = $urandom;
          pw[2'(k)] = $urandom;
          ps[2'(k)] = 4'($urandom);
          since[2'(k)] = 0;
          set_req(k, pa[2'(k)], pw[2'(k)], ps[2'(k)]);
        end
      up_valid = pend;
      prev_req = pend;
      prev_dv = dn_valid;
      prev_idle = cur_idle;
      prev_resp = (up_ready !== 4'b0);
    end
    checks++;
    if (done < 50) begin
      failures++;
      $display("FAIL rand_throughput: %0d completions in 600 cycles, expected at least 50", done);
    end
    up_valid = '0;
    dn_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_write();
    test_watchdog();
    test_async_reset();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
